// File: rtl/acc_unit_pipe_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg
//   Shared types and the compute function of the streaming accelerator.
//   acc_op_t     : operation select carried with every operand
//   ACC_LEGACY_W : word width of the original fixed half-sum accelerator
//   ACC_MAX_W    : widest DATA_W the compute function supports
//   acc_compute  : returns {sat, result} for one operand word
// ---------------------------------------------------------------------------
package acc_pkg;

   typedef enum logic [1:0] {
      ACC_SUM    = 2'd0,
      ACC_POPCNT = 2'd1,
      ACC_BREV   = 2'd2,
      ACC_SATSUM = 2'd3
   } acc_op_t;

   localparam int ACC_LEGACY_W = 32;
   localparam int ACC_MAX_W    = 128;

   typedef logic [ACC_MAX_W-1:0] acc_word_t;
   typedef logic [ACC_MAX_W:0]   acc_out_t;

   // Works on a zero-extended word of ACC_MAX_W bits; data_w selects the real
   // operand width. The sat flag is placed at bit data_w so a caller can
   // truncate the return value to data_w+1 bits and get {sat, result}.
   function automatic acc_out_t acc_compute(input acc_word_t data,
                                            input acc_op_t   op,
                                            input int        data_w);
      int             h;
      int             nbytes;
      int             cnt;
      acc_word_t      mask;
      acc_word_t      hi;
      acc_word_t      lo;
      acc_word_t      res;
      logic [ACC_MAX_W:0] sum;
      logic           ovf;
      logic           sat;
      acc_out_t       ret;

      h      = data_w / 2;
      nbytes = data_w / 8;
      mask   = {ACC_MAX_W{1'b1}} >> (ACC_MAX_W - h);
      hi     = (data >> h) & mask;
      lo     = data & mask;
      sum    = {1'b0, hi} + {1'b0, lo};
      // Carry out of the H-bit half sum
      ovf    = sum[h];
      res    = '0;
      sat    = 1'b0;
      cnt    = 0;

      case (op)
         ACC_SUM: begin
            res = sum[ACC_MAX_W-1:0] & mask;
         end
         ACC_POPCNT: begin
            for (int i = 0; i < ACC_MAX_W; i++) begin
               if (data[i]) cnt++;
            end
            res = acc_word_t'(cnt);
         end
         ACC_BREV: begin
            for (int b = 0; b < ACC_MAX_W / 8; b++) begin
               if (b < nbytes) res[b*8 +: 8] = data[(nbytes-1-b)*8 +: 8];
            end
         end
         ACC_SATSUM: begin
            if (ovf) begin
               res = mask;
               sat = 1'b1;
            end else begin
               res = sum[ACC_MAX_W-1:0] & mask;
            end
         end
         default: res = '0;
      endcase

      ret         = {1'b0, res};
      ret[data_w] = sat;
      return ret;
   endfunction

endpackage

// File: rtl/acc_unit_pipe_if.sv
// ---------------------------------------------------------------------------
// acc_unit_pipe_if
//   Operand and result streams of acc_unit_pipe.
//   arg_* : operand stream, producer -> unit (arg_ready driven by the unit)
//   res_* : result stream, unit -> consumer (res_ready driven by the consumer)
//
//   Handshake rule for both streams: a transfer happens on a rising clock
//   edge where valid && ready are both high. Once valid is raised, the
//   payload stays stable until that transfer. ready may be high with valid
//   low. Neither side's ready depends combinationally on the other stream.
//
//   master : the processor-side producer/consumer
//   slave  : the accelerator
// ---------------------------------------------------------------------------
interface acc_unit_pipe_if
   import acc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 6
);

   logic              arg_valid;
   logic              arg_ready;
   logic [DATA_W-1:0] arg_data;
   acc_op_t           arg_op;
   logic [TAG_W-1:0]  arg_tag;

   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic [TAG_W-1:0]  res_tag;
   logic              res_sat;

   modport master (
      output arg_valid, arg_data, arg_op, arg_tag, res_ready,
      input  arg_ready, res_valid, res_data, res_tag, res_sat
   );

   modport slave (
      input  arg_valid, arg_data, arg_op, arg_tag, res_ready,
      output arg_ready, res_valid, res_data, res_tag, res_sat
   );

endinterface

// File: rtl/acc_unit_pipe_arg_fifo.sv
// ---------------------------------------------------------------------------
// acc_arg_fifo
//   Synchronous FIFO holding accepted operands until the pipeline takes them.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push       : write push_data at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : current head entry, valid when !empty
//   full/empty : occupancy flags
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module acc_arg_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/acc_unit_pipe.sv
// ---------------------------------------------------------------------------
// acc_unit_pipe
//   Streaming accelerator: operands are buffered in an argument FIFO, run
//   through a selectable operation, delayed by a LATENCY-deep stall-able
//   pipeline and returned in acceptance order with their tag.
//   clk, rst_n : clock, asynchronous active-low reset (sync release)
//   bus        : operand/result streams (acc_unit_pipe_if.slave)
//   busy       : FIFO non-empty or any pipeline stage valid
//   in_flight  : accepted items not yet taken by the consumer
// ---------------------------------------------------------------------------
module acc_unit_pipe
   import acc_pkg::*;
#(
   parameter  int DATA_W    = 32,
   parameter  int TAG_W     = 6,
   parameter  int ARG_DEPTH = 4,
   parameter  int LATENCY   = 2,
   localparam int CNT_W     = $clog2(ARG_DEPTH + LATENCY + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   acc_unit_pipe_if.slave   bus,
   output logic             busy,
   output logic [CNT_W-1:0] in_flight
);

   // DATA_W must not exceed ACC_MAX_W of acc_pkg.

   typedef struct packed {
      acc_op_t           op;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } arg_ent_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   arg_ent_t          push_ent;
   arg_ent_t          head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              adv;
   logic              take;
   logic [DATA_W:0]   comp;

   logic [LATENCY-1:0] st_valid;
   logic [LATENCY-1:0] st_sat;
   logic [DATA_W-1:0]  st_data [LATENCY];
   logic [TAG_W-1:0]   st_tag  [LATENCY];

   assign push_ent = '{op: bus.arg_op, tag: bus.arg_tag, data: bus.arg_data};

   // arg_ready is only the registered full flag, so a same-cycle pop never
   // opens it; there is no path from res_ready to arg_ready.
   assign push = bus.arg_valid && !fifo_full;
   assign adv  = !st_valid[LATENCY-1] || bus.res_ready;
   assign pop  = adv && !fifo_empty;
   assign take = st_valid[LATENCY-1] && bus.res_ready;

   acc_arg_fifo #(
      .WIDTH ($bits(arg_ent_t)),
      .DEPTH (ARG_DEPTH)
   ) u_arg_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_ent),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Truncating to DATA_W+1 bits keeps {sat, result}.
   always_comb begin
      comp = (DATA_W+1)'(acc_compute(acc_word_t'(head.data), head.op, DATA_W));
   end

   // Whole pipeline moves together; bubbles are not squeezed out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_valid <= '0;
         st_sat   <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            st_data[i] <= '0;
            st_tag[i]  <= '0;
         end
      end else if (adv) begin
         st_valid[0] <= !fifo_empty;
         st_sat[0]   <= fifo_empty ? 1'b0 : comp[DATA_W];
         st_data[0]  <= fifo_empty ? '0 : comp[DATA_W-1:0];
         st_tag[0]   <= fifo_empty ? '0 : head.tag;
         for (int i = 1; i < LATENCY; i++) begin
            st_valid[i] <= st_valid[i-1];
            st_sat[i]   <= st_sat[i-1];
            st_data[i]  <= st_data[i-1];
            st_tag[i]   <= st_tag[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_flight <= '0;
      end else if (push && !take) begin
         in_flight <= in_flight + CNT_ONE;
      end else if (!push && take) begin
         in_flight <= in_flight - CNT_ONE;
      end
   end

   assign bus.arg_ready = !fifo_full;
   assign bus.res_valid = st_valid[LATENCY-1];
   assign bus.res_data  = st_data[LATENCY-1];
   assign bus.res_tag   = st_tag[LATENCY-1];
   assign bus.res_sat   = st_sat[LATENCY-1];
   assign busy          = !fifo_empty || (|st_valid);

endmodule

// File: tb/tb_acc_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_acc_unit_pipe
//   Self-checking bench for acc_unit_pipe: directed vector table, hand-built
//   back-pressure and reset sequences, and a randomized stream checked by a
//   scoreboard fed from an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_acc_unit_pipe;
   import acc_pkg::*;

   localparam int DATA_W    = 32;
   localparam int TAG_W     = 6;
   localparam int ARG_DEPTH = 4;
   localparam int LATENCY   = 2;
   localparam int CNT_W     = $clog2(ARG_DEPTH + LATENCY + 1);
   localparam int H         = DATA_W / 2;
   localparam int SB_W      = 1 + TAG_W + DATA_W;
   localparam int CAP       = ARG_DEPTH + LATENCY;

   typedef logic [DATA_W-1:0] dw_t;

   typedef struct {
      dw_t              data;
      acc_op_t          op;
      logic [TAG_W-1:0] tag;
      dw_t              exp_data;
      logic             exp_sat;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             busy;
   logic [CNT_W-1:0] in_flight;

   int checks = 0;
   int errors = 0;
   int n_acc  = 0;

   logic [SB_W-1:0] exp_q[$];
   vec_t            vecs[13];

   acc_unit_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   acc_unit_pipe #(
      .DATA_W    (DATA_W),
      .TAG_W     (TAG_W),
      .ARG_DEPTH (ARG_DEPTH),
      .LATENCY   (LATENCY)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .busy      (busy),
      .in_flight (in_flight)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Returns {sat, tag, result} from plain integer arithmetic.
   function automatic logic [SB_W-1:0] model(input dw_t d, input acc_op_t op,
                                             input logic [TAG_W-1:0] tag);
      longint unsigned lim;
      longint unsigned s;
      dw_t             r;
      dw_t             br;
      logic            sat;
      lim = 64'd1 << H;
      s   = (longint'(d) / lim) + (longint'(d) % lim);
      sat = 1'b0;
      br  = {<<8{d}};
      case (op)
         ACC_SUM:    r = dw_t'(s % lim);
         ACC_POPCNT: r = dw_t'($countones(d));
         ACC_BREV:   r = br;
         default: begin
            if (s >= lim) begin
               r   = dw_t'(lim - 1);
               sat = 1'b1;
            end else begin
               r = dw_t'(s);
            end
         end
      endcase
      return {sat, tag, r};
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // ---------------- scoreboard monitor ----------------
   // Samples on the falling edge; the handshakes it sees are the ones the
   // next rising edge will perform.
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_flight", 64'(in_flight), 64'(exp_q.size()));
         check("busy", 64'(busy), 64'(exp_q.size() != 0));
         if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_result");
            end else begin
               check("sb_data", 64'(bus.res_data), 64'(exp_q[0][DATA_W-1:0]));
               check("sb_tag",  64'(bus.res_tag),  64'(exp_q[0][DATA_W +: TAG_W]));
               check("sb_sat",  64'(bus.res_sat),  64'(exp_q[0][SB_W-1]));
               if (bus.res_ready) void'(exp_q.pop_front());
            end
         end
         if (bus.arg_valid && bus.arg_ready) begin
            exp_q.push_back(model(bus.arg_data, bus.arg_op, bus.arg_tag));
            n_acc++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_item(input dw_t d, input acc_op_t op, input logic [TAG_W-1:0] tag);
      bus.arg_valid = 1'b1;
      bus.arg_data  = d;
      bus.arg_op    = op;
      bus.arg_tag   = tag;
   endtask

   task automatic drive_random_item();
      dw_t d;
      d = dw_t'($urandom());
      if ($urandom_range(0, 3) == 0) d[DATA_W-1:H] = '1;
      drive_item(d, acc_op_t'($urandom_range(0, 3)), TAG_W'($urandom_range(0, 63)));
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic push_item(input dw_t d, input acc_op_t op, input logic [TAG_W-1:0] tag);
      int n;
      n = 0;
      drive_item(d, op, tag);
      @(negedge clk);
      while (!bus.arg_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!bus.arg_ready) fail_now("push_timeout");
      @(posedge clk);
      #1 bus.arg_valid = 1'b0;
   endtask

   // Counts rising edges until res_valid shows, sampled 1 time unit later.
   task automatic wait_result(output int lat, output bit seen);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.res_valid && lat < 50);
      seen = bus.res_valid;
      if (!seen) fail_now("result_timeout");
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int  lat;
      bit  seen;
      int  acc;
      int  target;
      int  c;

      bus.arg_valid = 1'b0;
      bus.arg_data  = '0;
      bus.arg_op    = ACC_SUM;
      bus.arg_tag   = '0;
      bus.res_ready = 1'b1;

      vecs[0]  = '{32'h0003_0004, ACC_SUM,    6'd1,  32'h0000_0007, 1'b0};
      vecs[1]  = '{32'hFFFF_0001, ACC_SUM,    6'd2,  32'h0000_0000, 1'b0};
      vecs[2]  = '{32'hFFFF_0001, ACC_SATSUM, 6'd3,  32'h0000_FFFF, 1'b1};
      vecs[3]  = '{32'h7FFF_0001, ACC_SATSUM, 6'd4,  32'h0000_8000, 1'b0};
      vecs[4]  = '{32'hF0F0_0001, ACC_POPCNT, 6'd5,  32'h0000_0009, 1'b0};
      vecs[5]  = '{32'h1122_3344, ACC_BREV,   6'd17, 32'h4433_2211, 1'b0};
      vecs[6]  = '{32'hFFFF_0000, ACC_SATSUM, 6'd6,  32'h0000_FFFF, 1'b0};
      vecs[7]  = '{32'h8000_8000, ACC_SATSUM, 6'd7,  32'h0000_FFFF, 1'b1};
      vecs[8]  = '{32'h8000_8000, ACC_SUM,    6'd8,  32'h0000_0000, 1'b0};
      vecs[9]  = '{32'hFFFF_FFFF, ACC_POPCNT, 6'd63, 32'h0000_0020, 1'b0};
      vecs[10] = '{32'h0000_0000, ACC_POPCNT, 6'd0,  32'h0000_0000, 1'b0};
      vecs[11] = '{32'h0000_00FF, ACC_BREV,   6'd42, 32'hFF00_0000, 1'b0};
      vecs[12] = '{32'h1234_5678, ACC_SUM,    6'd9,  32'h0000_68AC, 1'b0};

      // Reset values
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_arg_ready", 64'(bus.arg_ready), 64'd1);
      check("rst_res_valid", 64'(bus.res_valid), 64'd0);
      check("rst_res_data",  64'(bus.res_data),  64'd0);
      check("rst_res_tag",   64'(bus.res_tag),   64'd0);
      check("rst_res_sat",   64'(bus.res_sat),   64'd0);
      check("rst_busy",      64'(busy),          64'd0);
      check("rst_in_flight", 64'(in_flight),     64'd0);
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Vector table: one item at a time, latency and value per entry
      foreach (vecs[i]) begin
         push_item(vecs[i].data, vecs[i].op, vecs[i].tag);
         wait_result(lat, seen);
         check("vec_latency", 64'(lat), 64'(LATENCY));
         if (seen) begin
            check("vec_data", 64'(bus.res_data), 64'(vecs[i].exp_data));
            check("vec_sat",  64'(bus.res_sat),  64'(vecs[i].exp_sat));
            check("vec_tag",  64'(bus.res_tag),  64'(vecs[i].tag));
         end
      end
      @(posedge clk);
      #1;

      // Back-to-back pair: tags come back in order on consecutive cycles
      drive_item(32'h1122_3344, ACC_BREV, 6'd5);
      @(posedge clk);
      #1 drive_item(32'hF0F0_0001, ACC_POPCNT, 6'd17);
      @(posedge clk);
      #1 bus.arg_valid = 1'b0;
      wait_result(lat, seen);
      check("pair_first_tag",  64'(bus.res_tag),  64'd5);
      check("pair_first_data", 64'(bus.res_data), 64'h4433_2211);
      @(posedge clk);
      #1;
      check("pair_second_valid", 64'(bus.res_valid), 64'd1);
      check("pair_second_tag",   64'(bus.res_tag),   64'd17);
      check("pair_second_data",  64'(bus.res_data),  64'd9);
      repeat (3) @(posedge clk);
      #1;

      // Capacity under back-pressure
      bus.res_ready = 1'b0;
      drive_random_item();
      acc = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!bus.arg_ready) break;
         @(posedge clk);
         acc++;
         #1 drive_random_item();
      end
      @(posedge clk);
      #1 bus.arg_valid = 1'b0;
      check("cap_accepted",  64'(acc),           64'(CAP));
      check("cap_arg_ready", 64'(bus.arg_ready), 64'd0);
      check("cap_in_flight", 64'(in_flight),     64'(CAP));

      // Release: CAP results on consecutive cycles, ready returns after first pop
      bus.res_ready = 1'b1;
      for (int k = 0; k < CAP; k++) begin
         @(negedge clk);
         check("drain_valid", 64'(bus.res_valid), 64'd1);
         if (k == 0) check("drain_ready_before", 64'(bus.arg_ready), 64'd0);
         if (k == 1) check("drain_ready_after",  64'(bus.arg_ready), 64'd1);
      end
      @(negedge clk);
      check("drain_done_valid", 64'(bus.res_valid), 64'd0);
      check("drain_done_busy",  64'(busy),          64'd0);
      @(posedge clk);
      #1;

      // Random stream with random back-pressure
      target = n_acc + 1000;
      c = 0;
      while (c < 20000 && n_acc < target) begin
         @(posedge clk);
         #1;
         c++;
         bus.res_ready = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 9) < 7) drive_random_item();
         else bus.arg_valid = 1'b0;
      end
      bus.arg_valid = 1'b0;
      bus.res_ready = 1'b1;
      if (n_acc < target) fail_now("random_stream_timeout");
      c = 0;
      while (c < 200 && exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("random_drained", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;

      // Asynchronous reset with items in flight
      bus.res_ready = 1'b0;
      drive_item(32'h0001_0001, ACC_SUM, 6'd11);
      repeat (3) @(posedge clk);
      #1 bus.arg_valid = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_in_flight", 64'(in_flight),     64'd3);
      check("pre_rst_res_valid", 64'(bus.res_valid), 64'd1);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("async_rst_res_valid", 64'(bus.res_valid), 64'd0);
      check("async_rst_busy",      64'(busy),          64'd0);
      check("async_rst_in_flight", 64'(in_flight),     64'd0);
      check("async_rst_arg_ready", 64'(bus.arg_ready), 64'd1);
      @(posedge clk);
      #3 rst_n = 1'b1;
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      push_item(32'h0003_0004, ACC_SUM, 6'd9);
      wait_result(lat, seen);
      check("post_rst_latency", 64'(lat), 64'(LATENCY));
      if (seen) begin
         check("post_rst_data", 64'(bus.res_data), 64'd7);
         check("post_rst_tag",  64'(bus.res_tag),  64'd9);
      end
      repeat (3) @(posedge clk);
      #1;

      // ---------------- final report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
